// File: rtl/mem_pkg.sv
// Shared constants and types for the memory data-port arbiter.
package mem_pkg;

    // Default scalar/address width and vector data width.
    localparam int unsigned MEM_S = 32;
    localparam int unsigned MEM_V = 192;

    // Data memory map: [ROM_BASE, RAM_BASE) is ROM, [RAM_BASE, RAM_END) is RAM.
    localparam int unsigned ROM_BASE = 1000;
    localparam int unsigned RAM_BASE = 31000;
    localparam int unsigned RAM_END  = 61015;

    // Sequencer states: accept a command, drive the memory for one cycle, respond.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // One latched memory command.
    typedef struct packed {
        logic             we;
        logic             vec;
        logic [MEM_S-1:0] addr;
        logic [MEM_V-1:0] wd;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The requester that did not win last time has
// priority on a tie; last_grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    // One-hot grant from the valids; nothing is granted while disabled.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    // Remember the winner of every granted cycle.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_o != 2'b00) begin
            last_grant_d = grant_o[1];
        end
    end

    // last_grant register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memoryController data port between the core memory stage
// (requester 0) and the vector/image-init engine (requester 1).
// Handshake: a command transfers in a cycle where reqX_valid and reqX_ready are
// both 1. ready is only offered in IDLE, to the arbitration winner, and depends
// combinationally on valid; valid may stay high while waiting. The response is a
// one-cycle reqX_rvalid pulse two cycles after the transfer, with rdata/err.
module mem_port_arbiter #(
    parameter int unsigned S        = mem_pkg::MEM_S,
    parameter int unsigned V        = mem_pkg::MEM_V,
    parameter int unsigned ROM_BASE = mem_pkg::ROM_BASE,
    parameter int unsigned RAM_BASE = mem_pkg::RAM_BASE,
    parameter int unsigned RAM_END  = mem_pkg::RAM_END
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_we,
    input  logic         req0_vec,
    input  logic [S-1:0] req0_addr,
    input  logic [V-1:0] req0_wd,
    output logic         req0_rvalid,
    output logic [V-1:0] req0_rdata,
    output logic         req0_err,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_we,
    input  logic         req1_vec,
    input  logic [S-1:0] req1_addr,
    input  logic [V-1:0] req1_wd,
    output logic         req1_rvalid,
    output logic [V-1:0] req1_rdata,
    output logic         req1_err,
    output logic         mem_we,
    output logic         mem_vec,
    output logic [S-1:0] mem_addr,
    output logic [V-1:0] mem_wd,
    input  logic [V-1:0] mem_rd,
    output logic         busy
);

    import mem_pkg::*;

    state_e   state_q, state_d;
    mem_req_t req_q, req_d;
    logic     owner_q, owner_d;
    logic     err_q, err_d;
    logic [V-1:0] rdata0_q, rdata1_q;
    logic [V-1:0] resp_d;
    logic [1:0]   grant;

    // Arbitration is only open in IDLE and never while reset is asserted.
    rr_arbiter2 u_rr_arbiter2 (
        .clk_i    (clk),
        .rst_ni   (rst),
        .valid_i  ({req1_valid, req0_valid}),
        .enable_i ((state_q == IDLE) && rst),
        .grant_o  (grant)
    );

    // Next state: latch the winner's command and its map check, then issue and respond.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant[1];
                    if (grant[1]) begin
                        req_d = '{we: req1_we, vec: req1_vec, addr: req1_addr, wd: req1_wd};
                    end else begin
                        req_d = '{we: req0_we, vec: req0_vec, addr: req0_addr, wd: req0_wd};
                    end
                    // Outside the map, or a write below RAM (ROM), is rejected.
                    err_d = (req_d.addr < S'(ROM_BASE)) || (req_d.addr >= S'(RAM_END)) ||
                            (req_d.we && (req_d.addr < S'(RAM_BASE)));
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes and rejected accesses return zero data.
    always_comb begin
        resp_d = (req_q.we || err_q) ? '0 : mem_rd;
    end

    // Control and command registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Per-requester response data, captured at the end of ISSUE and held until the next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == ISSUE) begin
            if (owner_q) begin
                rdata1_q <= resp_d;
            end else begin
                rdata0_q <= resp_d;
            end
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign req0_rvalid = (state_q == RESP) && !owner_q;
    assign req1_rvalid = (state_q == RESP) && owner_q;
    assign req0_err    = req0_rvalid && err_q;
    assign req1_err    = req1_rvalid && err_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    // The write strobe exists only in ISSUE, so an async reset drops it at once.
    assign mem_we   = (state_q == ISSUE) && req_q.we && !err_q;
    assign mem_vec  = req_q.vec;
    assign mem_addr = err_q ? '0 : req_q.addr;
    assign mem_wd   = req_q.wd;
    assign busy     = (state_q != IDLE);

endmodule
